// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounces MODE/INC, walks hour/minute edit modes with
// auto-repeat and timeout, and emits a one-cycle load of the edited time.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 8,
  parameter int TIMEOUT_TICKS   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       btn_mode_raw_i,
  input  logic       btn_inc_raw_i,
  input  logic [3:0] cur_hours_i,
  input  logic [5:0] cur_minutes_i,
  input  logic       cur_am_pm_i,
  output logic       hold_o,
  output logic       load_o,
  output logic [3:0] load_hours_o,
  output logic [5:0] load_minutes_o,
  output logic       load_am_pm_o,
  output logic [1:0] mode_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] REP_MAX  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  // Captured live time may be out of range; force it into the legal window.
  function automatic logic [3:0] clamp_hours(input logic [3:0] h);
    if ((h == 4'd0) || (h > 4'd12)) clamp_hours = 4'd12;
    else                            clamp_hours = h;
  endfunction

  function automatic logic [5:0] clamp_minutes(input logic [5:0] m);
    if (m > 6'd59) clamp_minutes = 6'd0;
    else           clamp_minutes = m;
  endfunction

  function automatic logic [3:0] next_hours(input logic [3:0] h);
    if (h >= 4'd12) next_hours = 4'd1;
    else            next_hours = h + 4'd1;
  endfunction

  function automatic logic [5:0] next_minutes(input logic [5:0] m);
    if (m >= 6'd59) next_minutes = 6'd0;
    else            next_minutes = m + 6'd1;
  endfunction

  // Index 0 = MODE, index 1 = INC throughout the button path.
  logic [1:0]          sync1_q, sync2_q, deb_q, deb_d, deb_prev_q, press_q;
  logic [1:0][DW-1:0]  dcnt_q, dcnt_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic                rep_q, rep_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                timeout_s, inc_ev_s, edit_s;
  state_t              state_q, state_d;
  logic                hold_q, hold_d, load_q, load_d;
  logic [3:0]          lh_q, lh_d;
  logic [5:0]          lm_q, lm_d;
  logic                la_q, la_d;

  assign edit_s   = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
  assign inc_ev_s = press_q[1] | rep_q;

  // Debounce counters: run while the synchronised level disagrees, flip at the limit.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != deb_q[b]) begin
        if (dcnt_q[b] == DB_LAST) begin
          dcnt_d[b] = '0;
          deb_d[b]  = sync2_q[b];
        end else begin
          dcnt_d[b] = dcnt_q[b] + DW'(1);
        end
      end else begin
        dcnt_d[b] = '0;
      end
    end
  end

  // Auto-repeat: count ticks while INC is held in an edit mode, saturating at the delay.
  always_comb begin
    hcnt_d = hcnt_q;
    rep_d  = 1'b0;
    if (!edit_s || !deb_q[1]) begin
      hcnt_d = '0;
    end else if (tick_i) begin
      if (hcnt_q == REP_MAX) begin
        rep_d = 1'b1;
      end else begin
        hcnt_d = hcnt_q + HW'(1);
        rep_d  = (hcnt_q == REP_LAST);
      end
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // Edit inactivity timeout; any press or increment restarts it.
  always_comb begin
    tcnt_d    = tcnt_q;
    timeout_s = 1'b0;
    if (!edit_s || press_q[0] || inc_ev_s) begin
      tcnt_d = '0;
    end else if (tick_i) begin
      if (tcnt_q == TO_LAST) begin
        tcnt_d    = '0;
        timeout_s = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  // Edit FSM; MODE takes priority over a same-cycle increment.
  always_comb begin
    state_d = state_q;
    lh_d    = lh_q;
    lm_d    = lm_q;
    la_d    = la_q;
    case (state_q)
      ST_RUN: begin
        if (press_q[0]) begin
          state_d = ST_SET_HOUR;
          lh_d    = clamp_hours(cur_hours_i);
          lm_d    = clamp_minutes(cur_minutes_i);
          la_d    = cur_am_pm_i;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SET_HOUR: begin
        if (press_q[0]) begin
          state_d = ST_SET_MIN;
        end else if (inc_ev_s) begin
          lh_d = next_hours(lh_q);
          la_d = (lh_q == 4'd11) ? ~la_q : la_q;
        end else if (timeout_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SET_HOUR;
        end
      end
      ST_SET_MIN: begin
        if (press_q[0]) begin
          state_d = ST_COMMIT;
        end else if (inc_ev_s) begin
          lm_d = next_minutes(lm_q);
        end else if (timeout_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SET_MIN;
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    hold_d = (state_d != ST_RUN);
    load_d = (state_d == ST_COMMIT);
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      press_q    <= 2'b00;
      dcnt_q     <= '0;
      hcnt_q     <= '0;
      rep_q      <= 1'b0;
      tcnt_q     <= '0;
      state_q    <= ST_RUN;
      hold_q     <= 1'b0;
      load_q     <= 1'b0;
      lh_q       <= 4'd12;
      lm_q       <= 6'd0;
      la_q       <= 1'b0;
    end else begin
      sync1_q    <= {btn_inc_raw_i, btn_mode_raw_i};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      dcnt_q     <= dcnt_d;
      hcnt_q     <= hcnt_d;
      rep_q      <= rep_d;
      tcnt_q     <= tcnt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      load_q     <= load_d;
      lh_q       <= lh_d;
      lm_q       <= lm_d;
      la_q       <= la_d;
    end
  end

  assign hold_o         = hold_q;
  assign load_o         = load_q;
  assign load_hours_o   = lh_q;
  assign load_minutes_o = lm_q;
  assign load_am_pm_o   = la_q;
  assign mode_o         = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/repeat/timeout settings.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       mode_raw, inc_raw;
  logic [3:0] cur_h;
  logic [5:0] cur_m;
  logic       cur_ap;
  logic       hold, load, ld_ap;
  logic [3:0] ld_h;
  logic [5:0] ld_m;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;
  int load_seen = 0;
  int load_base;
  int lat;
  logic [3:0] cap_h;
  logic [5:0] cap_m;
  logic       cap_ap, cap_hold, post_hold, after_load;
  logic [1:0] cap_mode, post_mode;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (3),
    .TIMEOUT_TICKS  (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick_i        (tick),
    .btn_mode_raw_i(mode_raw),
    .btn_inc_raw_i (inc_raw),
    .cur_hours_i   (cur_h),
    .cur_minutes_i (cur_m),
    .cur_am_pm_i   (cur_ap),
    .hold_o        (hold),
    .load_o        (load),
    .load_hours_o  (ld_h),
    .load_minutes_o(ld_m),
    .load_am_pm_o  (ld_ap),
    .mode_o        (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given tick level; records any load pulse and the cycle after it.
  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    if (after_load) begin
      post_mode  = mode;
      post_hold  = hold;
      after_load = 1'b0;
    end
    if (load === 1'b1) begin
      load_seen++;
      cap_h      = ld_h;
      cap_m      = ld_m;
      cap_ap     = ld_ap;
      cap_hold   = hold;
      cap_mode   = mode;
      after_load = 1'b1;
    end
  endtask

  task automatic press(input logic m, input logic i);
    mode_raw = m;
    inc_raw  = i;
    repeat (10) step(1'b0);
    mode_raw = 1'b0;
    inc_raw  = 1'b0;
    repeat (10) step(1'b0);
  endtask

  task automatic tick_period();
    step(1'b1);
    repeat (9) step(1'b0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; mode_raw = 1'b0; inc_raw = 1'b0;
    cur_h = 4'd11; cur_m = 6'd59; cur_ap = 1'b0;
    after_load = 1'b0; post_mode = 2'd3; post_hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mode", mode, 2'd0);
    check("reset_hold", hold, 1'b0);
    check("reset_load", load, 1'b0);
    check("reset_hours", ld_h, 4'd12);
    check("reset_minutes", ld_m, 6'd0);
    check("reset_ampm", ld_ap, 1'b0);
    rst = 1'b0;
    repeat (3) step(1'b0);

    // Bouncing MODE: 2 high, 1 low, then held.
    mode_raw = 1'b1; step(1'b0); step(1'b0);
    mode_raw = 1'b0; step(1'b0);
    mode_raw = 1'b1;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0);
      if (lat == 99 && mode == 2'd1) lat = k;
    end
    checks++;
    assert (lat >= 7 && lat <= 9) else begin
      errors++;
      $error("FAIL bounce_latency: observed %0d expected 7..9", lat);
    end
    mode_raw = 1'b0;
    repeat (10) step(1'b0);
    check("bounce_single_event", mode, 2'd1);
    check("bounce_hold", hold, 1'b1);
    check("capture_hours", ld_h, 4'd11);
    check("capture_minutes", ld_m, 6'd59);
    check("capture_ampm", ld_ap, 1'b0);

    // 11:59 AM -> 12:00 PM commit.
    press(1'b0, 1'b1);
    check("hour_11_to_12", ld_h, 4'd12);
    check("hour_ampm_toggle", ld_ap, 1'b1);
    press(1'b1, 1'b0);
    check("enter_set_min", mode, 2'd2);
    press(1'b0, 1'b1);
    check("min_59_wrap", ld_m, 6'd0);
    check("min_no_carry", ld_h, 4'd12);
    load_base = load_seen;
    press(1'b1, 1'b0);
    check("commit_load_count", load_seen - load_base, 1);
    check("commit_hours", cap_h, 4'd12);
    check("commit_minutes", cap_m, 6'd0);
    check("commit_ampm", cap_ap, 1'b1);
    check("commit_hold", cap_hold, 1'b1);
    check("commit_mode", cap_mode, 2'd3);
    check("after_commit_mode", post_mode, 2'd0);
    check("after_commit_hold", post_hold, 1'b0);

    // INC in RUN is ignored.
    press(1'b0, 1'b1);
    check("run_inc_mode", mode, 2'd0);
    check("run_inc_hours", ld_h, 4'd12);
    check("run_hold_low", hold, 1'b0);

    // Auto-repeat from 12.
    cur_h = 4'd12; cur_m = 6'd58; cur_ap = 1'b0;
    press(1'b1, 1'b0);
    check("repeat_entry_hours", ld_h, 4'd12);
    inc_raw = 1'b1;
    repeat (8) step(1'b0);
    check("repeat_press_inc", ld_h, 4'd1);
    tick_period(); check("repeat_tick1", ld_h, 4'd1);
    tick_period(); check("repeat_tick2", ld_h, 4'd1);
    tick_period(); check("repeat_tick3", ld_h, 4'd2);
    tick_period(); check("repeat_tick4", ld_h, 4'd3);
    tick_period(); check("repeat_tick5", ld_h, 4'd4);
    tick_period(); check("repeat_tick6", ld_h, 4'd5);
    inc_raw = 1'b0;
    repeat (12) step(1'b0);
    repeat (3) tick_period();
    check("repeat_release", ld_h, 4'd5);
    check("repeat_ampm", ld_ap, 1'b0);

    // Minutes from 58.
    press(1'b1, 1'b0);
    check("min_entry", ld_m, 6'd58);
    press(1'b0, 1'b1); check("min_59", ld_m, 6'd59);
    press(1'b0, 1'b1); check("min_0", ld_m, 6'd0);
    press(1'b0, 1'b1); check("min_1", ld_m, 6'd1);
    check("min_hours_kept", ld_h, 4'd5);
    load_base = load_seen;
    press(1'b1, 1'b0);
    check("commit2_count", load_seen - load_base, 1);
    check("commit2_hours", cap_h, 4'd5);
    check("commit2_minutes", cap_m, 6'd1);

    // Timeout without load, then recapture.
    cur_h = 4'd7; cur_m = 6'd30; cur_ap = 1'b1;
    press(1'b1, 1'b0);
    check("to_capture_hours", ld_h, 4'd7);
    check("to_capture_ampm", ld_ap, 1'b1);
    load_base = load_seen;
    repeat (19) tick_period();
    check("to_before_mode", mode, 2'd1);
    step(1'b1);
    check("to_mode", mode, 2'd0);
    check("to_hold", hold, 1'b0);
    repeat (5) step(1'b0);
    check("to_no_load", load_seen - load_base, 0);
    cur_h = 4'd3; cur_m = 6'd15; cur_ap = 1'b0;
    press(1'b1, 1'b0);
    check("recapture_hours", ld_h, 4'd3);
    check("recapture_minutes", ld_m, 6'd15);
    check("recapture_ampm", ld_ap, 1'b0);

    // Simultaneous MODE and INC: MODE wins.
    press(1'b1, 1'b1);
    check("simul_mode", mode, 2'd2);
    check("simul_hours", ld_h, 4'd3);
    check("simul_minutes", ld_m, 6'd15);

    // Asynchronous reset mid-edit.
    rst = 1'b1;
    #1;
    check("rst_mid_mode", mode, 2'd0);
    check("rst_mid_hold", hold, 1'b0);
    check("rst_mid_load", load, 1'b0);
    check("rst_mid_hours", ld_h, 4'd12);
    check("rst_mid_minutes", ld_m, 6'd0);
    check("rst_mid_ampm", ld_ap, 1'b0);
    repeat (2) step(1'b0);
    rst = 1'b0;
    repeat (3) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
